pipe_stage_ctrl: RTL
====================

// Module: pipe_stage_ctrl
// PURPOSE
//  Parametrised per-stage control register for the 5-stage MIPS pipeline.
//  - Instantiated once each for E, M and W.
//  - Latches op/func/rt/rd and the low address bits from the previous stage.
//  - Supports stall (hold) and flush (bubble insertion).
//  - Decodes destination register A3, RegWr, MemWr and byte enables.
//  - Produces a saturating Tnew for the hazard unit.
// PARAMETERS
//  STAGE      1  stage index held by this register: 1=E, 2=M, 3=W
//  TNEW_W     2  width of tnew_out
//  ALU_RDY    2  stage index at which ALU/lui/ori results become available
//  LOAD_RDY   3  stage index at which load data becomes available
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  asynchronous, active-high; clears all state
//  en           in   1  1 = capture inputs; 0 = hold (stall)
//  clr          in   1  1 = load a bubble at the next edge
//  op_in        in   6  opcode from previous stage
//  func_in      in   6  funct from previous stage
//  rt_in        in   5  rt field
//  rd_in        in   5  rd field
//  addr_lo_in   in   2  ALU result [1:0]; used for byte enables
//  valid_out    out  1  register holds a real instruction (not a bubble)
//  op_out       out  6  registered opcode
//  func_out     out  6  registered funct
//  a3_out       out  5  destination register of the held instruction
//  regwr_out    out  1  held instruction writes the GRF (a3_out != 0)
//  mem_wr_out   out  1  held instruction is a store
//  mem_be_out   out  4  store byte enables
//  tnew_out     out  TNEW_W  cycles until the result is available
// BEHAVIOUR
//  Reset:
//  - On reset, all outputs and registers are 0 immediately, independent of clk.
//  - A bubble has valid=0 and op=func=0 (sll $0 = nop).
//  Update priority at posedge clk: reset > clr > en > hold.
//  - clr=1 loads a bubble even when en=0 (flush wins over stall).
//  - en=0 with clr=0 holds every register, including addr_lo.
//  - Otherwise the stage captures op/func/rt/rd/addr_lo and sets valid=1.
//  Latency: outputs reflect inputs 1 cycle after capture.
//  - All outputs are decoded from registered fields only.
//  - Outputs are combinational from the registers; no input-to-output path.
//  Decode (R-type op=0x00):
//  - addu f=0x21, subu f=0x23, jr f=0x08.
//  - ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04, j 0x02, jal 0x03.
//  - Unknown opcodes decode as nop.
//  a3_out:
//  - rd for addu/subu; rt for ori/lui/lw; 31 for jal; 0 otherwise.
//  - Forced to 0 when valid=0.
//  regwr_out = valid & (a3_out != 0).
//  - A write to $0 is never reported.
//  mem_wr_out = valid & store.
//  Tnew (saturating, computed in TNEW_W+1 bits):
//  - RDY = LOAD_RDY for loads; ALU_RDY for addu/subu/ori/lui; 0 for all others.
//  - tnew_out = (RDY > STAGE) ? RDY-STAGE : 0, clamped to 2^TNEW_W-1.
//  - Example: lw -> 2 at E, 1 at M, 0 at W.
//  - Example: addu -> 1 at E, 0 at M.
//  - jal -> 0 at every stage (PC+8 is available from E).
//  Byte enables:
//  - sw -> 4'b1111 regardless of addr_lo.
//  - Non-stores -> 4'b0000.
// CONFIGURATION
//  PIPE_BYTE_MEM_EN defined:
//  - Also decodes lb 0x20, lh 0x21, sb 0x28, sh 0x29.
//  - lb/lh: a3 = rt, RDY = LOAD_RDY.
//  - sb: be = 4'b0001 << addr_lo.
//  - sh: be = 4'b0011 if addr_lo=0, 4'b1100 if addr_lo=2.
//  - Misaligned sh (addr_lo[0]=1): be = 0, mem_wr_out still 1 (write dropped).
//  PIPE_BYTE_MEM_EN undefined:
//  - These four opcodes decode as nop: regwr=0, mem_wr=0, be=0, tnew=0.
// TESTING
//  1. reset=1 mid-cycle with a lw held -> all outputs 0 immediately;
//     release reset -> still 0 until the next capture.
//  2. STAGE=1, en=1, capture lw rt=5 -> a3=5, regwr=1, tnew=2;
//     same instruction in a STAGE=2 instance next cycle -> tnew=1.
//  3. addu rd=0 -> a3=0, regwr=0;
//     jal -> a3=31, regwr=1, tnew=0.
//  4. en=0 for 3 cycles while inputs change -> outputs unchanged;
//     en=0 & clr=1 -> bubble: valid=0, regwr=0, tnew=0.
//  5. sw with addr_lo=3 -> mem_wr=1, be=1111.
//     With PIPE_BYTE_MEM_EN: sb addr_lo=2 -> be=0100; sh addr_lo=1 -> be=0000.
//  6. Without PIPE_BYTE_MEM_EN: sb -> mem_wr=0, be=0000, regwr=0.

Source files
------------

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl -- per-stage control register for the 5-stage MIPS pipeline.
// One instance per stage (E, M, W), selected by STAGE. It latches the
// instruction fields from the previous stage, supports stall (hold) and flush
// (bubble), and decodes A3 / RegWr / MemWr / byte enables / Tnew from the held
// fields only.
// Optional feature macro: PIPE_BYTE_MEM_EN -- adds lb/lh/sb/sh decode. When it
// is undefined those opcodes decode as nop.
module pipe_stage_ctrl #(
  parameter int STAGE    = 1,
  parameter int TNEW_W   = 2,
  parameter int ALU_RDY  = 2,
  parameter int LOAD_RDY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [5:0]        op_in,
  input  logic [5:0]        func_in,
  input  logic [4:0]        rt_in,
  input  logic [4:0]        rd_in,
  input  logic [1:0]        addr_lo_in,
  output logic              valid_out,
  output logic [5:0]        op_out,
  output logic [5:0]        func_out,
  output logic [4:0]        a3_out,
  output logic              regwr_out,
  output logic              mem_wr_out,
  output logic [3:0]        mem_be_out,
  output logic [TNEW_W-1:0] tnew_out
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;
`ifdef PIPE_BYTE_MEM_EN
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
`endif

  // Stage-relative distances, worked out once at elaboration in TNEW_W+1 bits.
  localparam int TW_MAX    = (2 ** (TNEW_W + 1)) - 1;
  localparam int ALU_DIFF  = (ALU_RDY > STAGE) ? (ALU_RDY - STAGE) : 0;
  localparam int LOAD_DIFF = (LOAD_RDY > STAGE) ? (LOAD_RDY - STAGE) : 0;
  localparam int ALU_SAT   = (ALU_DIFF > TW_MAX) ? TW_MAX : ALU_DIFF;
  localparam int LOAD_SAT  = (LOAD_DIFF > TW_MAX) ? TW_MAX : LOAD_DIFF;
  localparam logic [TNEW_W:0] ALU_T    = ALU_SAT[TNEW_W:0];
  localparam logic [TNEW_W:0] LOAD_T   = LOAD_SAT[TNEW_W:0];
  localparam logic [TNEW_W:0] TNEW_MAX = {1'b0, {TNEW_W{1'b1}}};

  logic       valid_q, valid_d;
  logic [5:0] op_q, op_d;
  logic [5:0] func_q, func_d;
  logic [4:0] rt_q, rt_d;
  logic [4:0] rd_q, rd_d;
  logic [1:0] addr_lo_q, addr_lo_d;

  // Next-state: flush beats stall, stall holds everything including addr_lo.
  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    func_d    = func_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    addr_lo_d = addr_lo_q;
    if (clr) begin
      valid_d   = 1'b0;
      op_d      = 6'h00;
      func_d    = 6'h00;
      rt_d      = 5'd0;
      rd_d      = 5'd0;
      addr_lo_d = 2'd0;
    end else if (en) begin
      valid_d   = 1'b1;
      op_d      = op_in;
      func_d    = func_in;
      rt_d      = rt_in;
      rd_d      = rd_in;
      addr_lo_d = addr_lo_in;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      op_q      <= 6'h00;
      func_q    <= 6'h00;
      rt_q      <= 5'd0;
      rd_q      <= 5'd0;
      addr_lo_q <= 2'd0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      func_q    <= func_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      addr_lo_q <= addr_lo_d;
    end
  end

  logic [4:0]        a3_raw;
  logic              is_store;
  logic [3:0]        be_raw;
  logic [TNEW_W:0]   tnew_wide;

  // Instruction decode from the held fields; unknown encodings fall through as nop.
  always_comb begin
    a3_raw    = 5'd0;
    is_store  = 1'b0;
    be_raw    = 4'b0000;
    tnew_wide = '0;
    unique case (op_q)
      OP_RTYPE: begin
        if (func_q == FN_ADDU || func_q == FN_SUBU) begin
          a3_raw    = rd_q;
          tnew_wide = ALU_T;
        end else if (func_q == FN_JR) begin
          a3_raw = 5'd0;
        end
      end
      OP_ORI, OP_LUI: begin
        a3_raw    = rt_q;
        tnew_wide = ALU_T;
      end
      OP_LW: begin
        a3_raw    = rt_q;
        tnew_wide = LOAD_T;
      end
      OP_SW: begin
        is_store = 1'b1;
        be_raw   = 4'b1111;
      end
      // Link value (PC+8) already exists in E, so no wait is reported.
      OP_JAL: a3_raw = 5'd31;
      OP_J, OP_BEQ: a3_raw = 5'd0;
`ifdef PIPE_BYTE_MEM_EN
      OP_LB, OP_LH: begin
        a3_raw    = rt_q;
        tnew_wide = LOAD_T;
      end
      OP_SB: begin
        is_store = 1'b1;
        be_raw   = 4'b0001 << addr_lo_q;
      end
      // A misaligned halfword still counts as a store but writes no bytes.
      OP_SH: begin
        is_store = 1'b1;
        case (addr_lo_q)
          2'd0:    be_raw = 4'b0011;
          2'd2:    be_raw = 4'b1100;
          default: be_raw = 4'b0000;
        endcase
      end
`endif
      default: a3_raw = 5'd0;
    endcase
  end

`ifndef PIPE_BYTE_MEM_EN
  // addr_lo only matters for sub-word stores; keep it registered for stall semantics.
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_lo_q;
`endif

  assign valid_out  = valid_q;
  assign op_out     = op_q;
  assign func_out   = func_q;
  assign a3_out     = valid_q ? a3_raw : 5'd0;
  assign regwr_out  = valid_q & (a3_out != 5'd0);
  assign mem_wr_out = valid_q & is_store;
  assign mem_be_out = valid_q ? be_raw : 4'b0000;
  assign tnew_out   = !valid_q ? '0 :
                      (tnew_wide > TNEW_MAX) ? TNEW_MAX[TNEW_W-1:0] :
                      tnew_wide[TNEW_W-1:0];

endmodule
